// File: rtl/tlul_sram_slave.sv
// ---------------------------------------------------------------------------
// tlul_sram_slave
//
// Purpose:
//   TL-UL slave endpoint in the clk_24 domain that serves Get, PutFullData
//   and PutPartialData requests from a word-addressed internal memory.
//   One request is handled at a time: an accepted A-channel request
//   produces exactly one registered D-channel response (AccessAck or
//   AccessAckData), with d_error flagging illegal requests.
//
// Optional feature (compile-time macro):
//   TLUL_SRAM_WAIT_EN - inserts WAIT_CYCLES extra cycles of access latency
//                       between accept and response. When undefined, the
//                       response is valid exactly one cycle after accept.
//
// Ports:
//   clk_24                      slave-domain clock
//   reset                       synchronous, active-high reset
//   a_valid / a_ready           A-channel handshake
//   a_opcode, a_param, a_size,  A-channel request fields
//   a_source, a_address,
//   a_mask, a_data
//   d_valid / d_ready           D-channel handshake
//   d_opcode, d_param, d_size,  D-channel response fields
//   d_source, d_sink, d_data,
//   d_error
// ---------------------------------------------------------------------------
module tlul_sram_slave #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    SRC_WIDTH    = 2,
  parameter int                    SINK_WIDTH   = 1,
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE   = 32'h0000_0000,
  parameter int                    MEM_DEPTH    = 1024,
  parameter int                    WAIT_CYCLES  = 2
) (
  input  logic                    clk_24,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL    = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PARTIAL = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_GET         = OPCODE_WIDTH'(4);

  // Size of the served window in bytes, expressed in address width so the
  // range check is done entirely in ADDR_WIDTH arithmetic.
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef TLUL_SRAM_WAIT_EN
  localparam logic [1:0] ST_WAIT = 2'd1;
`endif
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

  logic [1:0]              r_state;
  logic                    r_dValid;
  logic [OPCODE_WIDTH-1:0] r_dOpcode;
  logic [SIZE_WIDTH-1:0]   r_dSize;
  logic [SRC_WIDTH-1:0]    r_dSource;
  logic [DATA_WIDTH-1:0]   r_dData;
  logic                    r_dError;
`ifdef TLUL_SRAM_WAIT_EN
  logic [3:0]              r_waitCnt;
  logic [IDX_W-1:0]        r_rdIdx;
  logic                    r_rdEn;
`endif

  logic                    w_aReady;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_offset;
  logic [IDX_W-1:0]        w_idx;
  logic [MASK_WIDTH-1:0]   w_expMask;
  logic                    w_opcodeOk;
  logic                    w_sizeOk;
  logic                    w_aligned;
  logic                    w_inRange;
  logic                    w_maskOk;
  logic                    w_error;
  logic                    w_legalGet;
  logic                    w_legalWrite;
  logic                    w_unused;

  // Request is accepted only from IDLE, and never while reset is asserted.
  assign w_aReady = (r_state == ST_IDLE) && !reset;
  assign w_accept = a_valid && w_aReady;

  // Offset into the served window; the range check guards indexing, so the
  // truncated word index below never aliases an out-of-window address.
  assign w_offset  = a_address - SLAVE_BASE;
  assign w_idx     = w_offset[IDX_W+1:2];
  assign w_inRange = (a_address >= SLAVE_BASE) && (w_offset < MEM_BYTES);

  // Byte lanes a request of this size/address is allowed to touch.
  always_comb begin
    w_expMask = '0;
    case (a_size)
      SIZE_WIDTH'(0): w_expMask = MASK_WIDTH'(1) << a_address[1:0];
      SIZE_WIDTH'(1): w_expMask = a_address[1] ? 4'b1100 : 4'b0011;
      SIZE_WIDTH'(2): w_expMask = 4'hF;
      default:        w_expMask = '0;
    endcase
  end

  // Legality checks; Get ignores a_mask entirely.
  always_comb begin
    w_opcodeOk = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL) ||
                 (a_opcode == OP_GET);
    w_sizeOk   = (a_size <= SIZE_WIDTH'(2));
    case (a_size)
      SIZE_WIDTH'(1): w_aligned = (a_address[0] == 1'b0);
      SIZE_WIDTH'(2): w_aligned = (a_address[1:0] == 2'b00);
      default:        w_aligned = 1'b1;
    endcase
    if (a_opcode == OP_PUT_FULL) begin
      w_maskOk = (a_mask == w_expMask);
    end else if (a_opcode == OP_PUT_PARTIAL) begin
      w_maskOk = ((a_mask & ~w_expMask) == '0);
    end else begin
      w_maskOk = 1'b1;
    end
    w_error      = !(w_opcodeOk && w_sizeOk && w_aligned && w_inRange && w_maskOk);
    w_legalGet   = !w_error && (a_opcode == OP_GET);
    w_legalWrite = !w_error && (a_opcode != OP_GET);
  end

  // Memory write port: writes commit at the accept edge, lane by lane.
  always_ff @(posedge clk_24) begin
    if (!reset && w_accept && w_legalWrite) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (a_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= a_data[8*b +: 8];
        end
      end
    end
  end

  // Request/response FSM with a single registered response slot. The
  // response fields are captured at accept and held until d_ready.
  always_ff @(posedge clk_24) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_dValid  <= 1'b0;
      r_dOpcode <= '0;
      r_dSize   <= '0;
      r_dSource <= '0;
      r_dData   <= '0;
      r_dError  <= 1'b0;
`ifdef TLUL_SRAM_WAIT_EN
      r_waitCnt <= '0;
      r_rdIdx   <= '0;
      r_rdEn    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dOpcode <= (a_opcode == OP_GET) ? OPCODE_WIDTH'(1) : '0;
            r_dSize   <= a_size;
            r_dSource <= a_source;
            r_dError  <= w_error;
`ifdef TLUL_SRAM_WAIT_EN
            r_state   <= ST_WAIT;
            r_waitCnt <= WAIT_LOAD;
            r_rdIdx   <= w_idx;
            r_rdEn    <= w_legalGet;
            r_dData   <= '0;
`else
            r_state   <= ST_RESP;
            r_dValid  <= 1'b1;
            r_dData   <= w_legalGet ? r_mem[w_idx] : '0;
`endif
          end
        end
`ifdef TLUL_SRAM_WAIT_EN
        // Read data is sampled on the way into RESP, after the wait expires.
        ST_WAIT: begin
          if (r_waitCnt == 4'd0) begin
            r_state  <= ST_RESP;
            r_dValid <= 1'b1;
            r_dData  <= r_rdEn ? r_mem[r_rdIdx] : '0;
          end else begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end
`endif
        ST_RESP: begin
          if (d_ready) begin
            r_state  <= ST_IDLE;
            r_dValid <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_dValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef TLUL_SRAM_WAIT_EN
  assign w_unused = ^a_param;
`else
  assign w_unused = ^{a_param, WAIT_LOAD};
`endif

  assign a_ready  = w_aReady;
  assign d_valid  = r_dValid;
  assign d_opcode = r_dOpcode;
  assign d_param  = '0;
  assign d_size   = r_dSize;
  assign d_source = r_dSource;
  assign d_sink   = '0;
  assign d_data   = r_dData;
  assign d_error  = r_dError;

endmodule

// File: tb/tb_tlul_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_tlul_sram_slave
//
// Directed and randomized TL-UL transactions against tlul_sram_slave. The
// expected response for every request comes from a byte-lane memory model
// and legality rules evaluated with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_tlul_sram_slave;

  localparam int          WAIT_CYCLES = 2;
  localparam int          MEM_DEPTH   = 1024;
  localparam logic [31:0] SLAVE_BASE  = 32'h0000_0000;
`ifdef TLUL_SRAM_WAIT_EN
  localparam int          EXP_LAT     = 1 + WAIT_CYCLES;
`else
  localparam int          EXP_LAT     = 1;
`endif

  logic        clk_24 = 1'b0;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [2:0]  d_size;
  logic [1:0]  d_source;
  logic [0:0]  d_sink;
  logic [31:0] d_data;
  logic        d_error;

  int          vectors     = 0;
  int          miscompares = 0;

  logic [31:0] modelMem [MEM_DEPTH];
  logic [2:0]  expOpcode;
  logic        expError;
  logic [31:0] expData;
  logic [2:0]  expSize;
  logic [1:0]  expSource;

  tlul_sram_slave #(
    .SLAVE_BASE (SLAVE_BASE),
    .MEM_DEPTH  (MEM_DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk_24   (clk_24),
    .reset    (reset),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_opcode (a_opcode),
    .a_param  (a_param),
    .a_size   (a_size),
    .a_source (a_source),
    .a_address(a_address),
    .a_mask   (a_mask),
    .a_data   (a_data),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_opcode (d_opcode),
    .d_param  (d_param),
    .d_size   (d_size),
    .d_source (d_source),
    .d_sink   (d_sink),
    .d_data   (d_data),
    .d_error  (d_error)
  );

  always #5 clk_24 = ~clk_24;

  // Hard stop in case something upstream of the bounded waits goes wrong.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: counts the vector and reports a miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Byte lanes [addr%4, addr%4 + 2^size) touched by a naturally sized access.
  function automatic logic [3:0] modelLanes(input logic [2:0] size,
                                            input logic [31:0] addr);
    logic [3:0] lanes;
    int lo;
    int n;
    lo = int'(addr % 4);
    n  = 1 << size;
    for (int b = 0; b < 4; b++) lanes[b] = (b >= lo) && (b < lo + n);
    return lanes;
  endfunction

  // Computes the expected response and applies the request to the model.
  task automatic modelPredict(input logic [2:0] op, input logic [2:0] size,
                              input logic [1:0] src, input logic [31:0] addr,
                              input logic [3:0] mask, input logic [31:0] data);
    longint     a;
    longint     lo;
    longint     hi;
    logic [3:0] lanes;
    bit         err;
    int         idx;
    a     = longint'(addr);
    lo    = longint'(SLAVE_BASE);
    hi    = lo + 4 * MEM_DEPTH;
    lanes = modelLanes(size, addr);
    err   = 0;
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) err = 1;
    if (size > 3'd2) err = 1;
    else if ((a % (64'sd1 << size)) != 0) err = 1;
    if (a < lo || a >= hi) err = 1;
    if (size <= 3'd2) begin
      if (op == 3'd0 && mask != lanes) err = 1;
      if (op == 3'd1 && (mask & ~lanes) != 4'd0) err = 1;
    end
    expOpcode = (op == 3'd4) ? 3'd1 : 3'd0;
    expSize   = size;
    expSource = src;
    expError  = err;
    expData   = 32'd0;
    if (!err) begin
      idx = int'((a - lo) / 4);
      if (op == 3'd4) begin
        expData = modelMem[idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) modelMem[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic checkResponse(input string tag);
    checkOutput({tag, "_d_opcode"}, 32'(d_opcode), 32'(expOpcode));
    checkOutput({tag, "_d_error"},  32'(d_error),  32'(expError));
    checkOutput({tag, "_d_data"},   d_data,        expData);
    checkOutput({tag, "_d_size"},   32'(d_size),   32'(expSize));
    checkOutput({tag, "_d_source"}, 32'(d_source), 32'(expSource));
    checkOutput({tag, "_d_param"},  32'(d_param),  32'd0);
    checkOutput({tag, "_d_sink"},   32'(d_sink),   32'd0);
    checkOutput({tag, "_a_ready"},  32'(a_ready),  32'd0);
  endtask

  // Issues one request, checks latency and response, optionally stalls
  // d_ready for a number of cycles, and optionally completes the handshake.
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [2:0] size, input logic [1:0] src,
                               input logic [31:0] addr, input logic [3:0] mask,
                               input logic [31:0] data, input int stall,
                               input bit doAck);
    int waited;
    int lat;
    @(negedge clk_24);
    a_opcode  = op;
    a_param   = 3'($urandom_range(0, 7));
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_valid   = 1'b1;
    d_ready   = 1'b0;
    waited    = 0;
    while (a_ready !== 1'b1 && waited < 20) begin
      @(negedge clk_24);
      waited++;
    end
    checkOutput({tag, "_a_ready_pre"}, 32'(a_ready), 32'd1);
    if (a_ready !== 1'b1) begin
      a_valid = 1'b0;
      return;
    end
    modelPredict(op, size, src, addr, mask, data);
    @(posedge clk_24);
    #1 a_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_24);
      lat++;
    end while (d_valid !== 1'b1 && lat < 40);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
    if (d_valid !== 1'b1) return;
    checkResponse(tag);
    repeat (stall) begin
      @(negedge clk_24);
      checkOutput({tag, "_stall_d_valid"}, 32'(d_valid), 32'd1);
      checkOutput({tag, "_stall_d_data"},  d_data,       expData);
      checkOutput({tag, "_stall_d_source"}, 32'(d_source), 32'(expSource));
      checkOutput({tag, "_stall_a_ready"}, 32'(a_ready), 32'd0);
    end
    if (doAck) begin
      d_ready = 1'b1;
      @(posedge clk_24);
      #1 d_ready = 1'b0;
      @(negedge clk_24);
      checkOutput({tag, "_a_ready_post"}, 32'(a_ready), 32'd1);
      checkOutput({tag, "_d_valid_post"}, 32'(d_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rAddr;
    logic [31:0] rData;
    logic [3:0]  rMask;
    logic [2:0]  rOp;
    logic [2:0]  rSize;
    int          pick;

    reset     = 1'b1;
    a_valid   = 1'b0;
    a_opcode  = 3'd0;
    a_param   = 3'd0;
    a_size    = 3'd0;
    a_source  = 2'd0;
    a_address = 32'd0;
    a_mask    = 4'd0;
    a_data    = 32'd0;
    d_ready   = 1'b0;
    repeat (3) @(negedge clk_24);

    // Reset state.
    checkOutput("rst_a_ready",  32'(a_ready),  32'd0);
    checkOutput("rst_d_valid",  32'(d_valid),  32'd0);
    checkOutput("rst_d_opcode", 32'(d_opcode), 32'd0);
    checkOutput("rst_d_data",   d_data,        32'd0);
    checkOutput("rst_d_error",  32'(d_error),  32'd0);
    checkOutput("rst_d_source", 32'(d_source), 32'd0);
    reset = 1'b0;
    @(negedge clk_24);
    checkOutput("rst_release_a_ready", 32'(a_ready), 32'd1);

    // Give the words exercised below known contents.
    for (int w = 0; w < 16; w++)
      applyStimulus("init", 3'd0, 3'd2, 2'd0, SLAVE_BASE + 32'(4 * w), 4'hF,
                    $urandom, 0, 1'b1);
    applyStimulus("init_top", 3'd0, 3'd2, 2'd0, SLAVE_BASE + 32'(4 * (MEM_DEPTH - 1)),
                  4'hF, $urandom, 0, 1'b1);

    // Full write then read back.
    applyStimulus("putfull", 3'd0, 3'd2, 2'd1, 32'h10, 4'hF, 32'hCAFE_BABE, 0, 1'b1);
    applyStimulus("get_after_put", 3'd4, 3'd2, 2'd2, 32'h10, 4'hF, 32'd0, 0, 1'b1);
    checkOutput("tp1_value", expData, 32'hCAFE_BABE);

    // Single-byte partial write merges into the stored word.
    applyStimulus("putpartial", 3'd1, 3'd0, 2'd3, 32'h12, 4'b0100, 32'h00AA_0000, 0, 1'b1);
    applyStimulus("get_merge", 3'd4, 3'd2, 2'd0, 32'h10, 4'h0, 32'd0, 0, 1'b1);
    checkOutput("tp2_d_data", d_data, 32'hCAAA_BABE);

    // Out-of-window read and just-inside top word.
    applyStimulus("get_oob", 3'd4, 3'd2, 2'd1, 32'h0000_1000, 4'hF, 32'd0, 0, 1'b1);
    applyStimulus("get_top", 3'd4, 3'd2, 2'd1, 32'h0000_0FFC, 4'hF, 32'd0, 0, 1'b1);

    // Illegal opcode and bad full-write mask leave memory untouched.
    applyStimulus("bad_opcode", 3'd2, 3'd2, 2'd0, 32'h4, 4'hF, 32'h1111_1111, 0, 1'b1);
    applyStimulus("bad_mask", 3'd0, 3'd2, 2'd0, 32'h4, 4'h7, 32'h2222_2222, 0, 1'b1);
    applyStimulus("get_unchanged", 3'd4, 3'd2, 2'd0, 32'h4, 4'hF, 32'd0, 0, 1'b1);

    // Misaligned halfword and partial mask outside the sized lanes.
    applyStimulus("misaligned", 3'd4, 3'd1, 2'd0, 32'h5, 4'hF, 32'd0, 0, 1'b1);
    applyStimulus("partial_out", 3'd1, 3'd1, 2'd0, 32'h8, 4'b0100, 32'hFFFF_FFFF, 0, 1'b1);

    // Backpressure on the response channel.
    applyStimulus("stall", 3'd4, 3'd2, 2'd3, 32'h10, 4'hF, 32'd0, 5, 1'b1);

    // Reset while a response is pending drops it.
    applyStimulus("pre_reset", 3'd4, 3'd2, 2'd2, 32'h10, 4'hF, 32'd0, 1, 1'b0);
    @(negedge clk_24);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_a_ready", 32'(a_ready), 32'd0);
    @(negedge clk_24);
    checkOutput("mid_rst_d_valid", 32'(d_valid), 32'd0);
    checkOutput("mid_rst_d_data",  d_data,       32'd0);
    reset = 1'b0;
    @(negedge clk_24);
    checkOutput("post_rst_a_ready", 32'(a_ready), 32'd1);
    checkOutput("post_rst_d_valid", 32'(d_valid), 32'd0);

    // Randomized traffic over the initialised words plus illegal cases.
    for (int t = 0; t < 80; t++) begin
      pick = int'($urandom_range(0, 9));
      if (pick <= 3)      rOp = 3'd4;
      else if (pick <= 5) rOp = 3'd0;
      else if (pick <= 7) rOp = 3'd1;
      else                rOp = 3'($urandom_range(0, 7));
      rSize = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      pick  = int'($urandom_range(0, 19));
      if (pick <= 16)
        rAddr = SLAVE_BASE + 32'($urandom_range(0, 63));
      else if (pick <= 18)
        rAddr = 32'h0000_1000 + 32'($urandom_range(0, 255));
      else
        rAddr = 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 0 && rSize <= 3'd2)
        rMask = modelLanes(rSize, rAddr);
      else
        rMask = 4'($urandom_range(0, 15));
      rData = $urandom;
      applyStimulus("rand", rOp, rSize, 2'($urandom_range(0, 3)), rAddr, rMask,
                    rData, int'($urandom_range(0, 2)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlul_sram_slave.md
Name: tlul_sram_slave

Overview:
TL-UL slave endpoint sitting directly downstream of the interconnect's slave socket, in the clk_24 domain. It consumes A-channel requests (Get, PutFullData, PutPartialData) and serves them from a word-addressed internal memory array. It returns exactly one D-channel response per request: AccessAck or AccessAckData, with a d_error flag for illegal requests. It processes one request at a time: a request-response FSM with a single registered response slot.

Parameters:
ADDR_WIDTH, 32, A-channel address width
DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes)
MASK_WIDTH, DATA_WIDTH/8, byte-mask width
SIZE_WIDTH, 3, a_size/d_size width
SRC_WIDTH, 2, source ID width
SINK_WIDTH, 1, sink ID width
OPCODE_WIDTH, 3, opcode width
PARAM_WIDTH, 3, param width
SLAVE_BASE, 32'h0000_0000, first byte address served
MEM_DEPTH, 1024, number of 32-bit words (power of 2)
WAIT_CYCLES, 2, extra access latency; used only with TLUL_SRAM_WAIT_EN (range 1..15)

Ports:
clk_24  in  1  slave-domain clock
reset  in  1  synchronous, active-high reset
a_valid  in  1  A request valid
a_ready  out  1  A request accepted when high together with a_valid
a_opcode  in  OPCODE_WIDTH  4=Get, 0=PutFullData, 1=PutPartialData
a_param  in  PARAM_WIDTH  ignored
a_size  in  SIZE_WIDTH  log2 bytes
a_source  in  SRC_WIDTH  requester ID
a_address  in  ADDR_WIDTH  byte address
a_mask  in  MASK_WIDTH  byte-lane enables
a_data  in  DATA_WIDTH  write data
d_valid  out  1  response valid
d_ready  in  1  response accepted
d_opcode  out  OPCODE_WIDTH  0=AccessAck, 1=AccessAckData
d_param  out  PARAM_WIDTH  always 0
d_size  out  SIZE_WIDTH  echoed a_size
d_source  out  SRC_WIDTH  echoed a_source
d_sink  out  SINK_WIDTH  always 0
d_data  out  DATA_WIDTH  read data (0 for non-Get or error)
d_error  out  1  request was illegal

Behaviour:
- Reset: a_ready=0 while reset is high, 1 from the first cycle after it; d_valid=0; all d_* fields 0; FSM=IDLE. Memory contents are not reset. Reset mid-WAIT/RESP drops the pending response; the FSM returns to IDLE.
- FSM states: IDLE, WAIT, RESP. a_ready=1 only in IDLE and not in reset.
- IDLE: on a_valid&&a_ready at edge T, capture opcode, size, source and error. Write (if legal) or read the memory at edge T. Go to RESP, so d_valid=1 from T+1.
- RESP: hold all d_* stable while d_valid&&!d_ready. On d_valid&&d_ready go to IDLE, so a_ready=1 the next cycle. Best-case throughput is 1 request per 2 cycles.
- Expected mask from size and address[1:0]:
  - size 0: one lane at addr[1:0]
  - size 1: lanes {addr[1],0} and {addr[1],1}
  - size 2: 4'hF
- Error if any of the following:
  - opcode not in {0,1,4}
  - size>2
  - address not aligned to 2^size
  - address<SLAVE_BASE or address>=SLAVE_BASE+4*MEM_DEPTH
  - PutFull with mask!=expected
  - PutPartial with mask having bits outside expected
  - Get ignores a_mask.
- Error response: no memory write; d_error=1; d_data=0; d_opcode=1 for Get, 0 for all other opcodes.
- Legal write: word index=(address-SLAVE_BASE)>>2. Only lanes with a_mask=1 are updated. Response is d_opcode=0, d_data=0.
- Legal Get: d_opcode=1; d_data=full stored word (all 4 lanes, regardless of size).
- Subtraction is done in ADDR_WIDTH bits; the range check precedes indexing, so no wrap-around access.

Optional Feature:
TLUL_SRAM_WAIT_EN:
- Defined: after accept, FSM goes IDLE->WAIT. A 4-bit counter loads WAIT_CYCLES-1 and decrements; at 0, FSM goes to RESP. d_valid first rises at T+1+WAIT_CYCLES. Writes still commit at edge T. Read data is captured at entry to RESP.
- Undefined: WAIT state and counter are absent; latency is exactly 1 cycle.

Test Plan:
- PutFullData addr 0x0000_0010, mask 4'hF, data 0xCAFEBABE, src 1, then Get addr 0x10 src 2 -> first response d_opcode=0/d_error=0/d_source=1; second response d_opcode=1, d_data=0xCAFEBABE, d_source=2, each d_valid one cycle after accept.
- PutPartialData addr 0x10, size 0, addr 0x12, mask 4'b0100, data 0x00AA0000, then Get 0x10 -> d_data=0xCAAABABE.
- Get addr 0x0000_1000 with MEM_DEPTH=1024 -> d_error=1, d_opcode=1, d_data=0; memory unchanged.
- Opcode 3'd2, then PutFull size 2 mask 4'h7 addr 0x4 -> both d_error=1; a subsequent Get 0x4 returns the prior contents.
- d_ready held low 5 cycles after a Get -> d_* stable, a_ready=0 throughout; d_ready=1 -> a_ready=1 next cycle.
- Reset pulsed during RESP -> d_valid=0 next cycle, a_ready=1 after release. With TLUL_SRAM_WAIT_EN and WAIT_CYCLES=2, a Get's d_valid rises 3 cycles after accept.
